// File: rtl/rotl_seq_pkg.sv
// rotl_seq_pkg: shared widths and FSM state encoding for the rotate-left sequencer
package rotl_seq_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/rotl_seq_if.sv
// rotl_seq_if: control/data bundle between a requester and the rotate-left sequencer
interface rotl_seq_if #(
  parameter int WIDTH = rotl_seq_pkg::WIDTH,
  parameter int CNT_W = rotl_seq_pkg::CNT_W
);
  logic             start;
  logic             clear;
  logic             hold;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] result;
  logic             serial_out;
  logic             busy;
  logic             done;
  modport master (
    output start, clear, hold, load_data, amount,
    input  result, serial_out, busy, done
  );
  modport slave (
    input  start, clear, hold, load_data, amount,
    output result, serial_out, busy, done
  );
endinterface

// File: rtl/rotl_seq.sv
// rotl_seq: loadable circular shifter rotating left one place per clock, MSB-first serial out
module rotl_seq
  import rotl_seq_pkg::*;
#(
  parameter int WIDTH = rotl_seq_pkg::WIDTH,
  parameter int CNT_W = rotl_seq_pkg::CNT_W
) (
  input logic   clock,
  input logic   reset,
  rotl_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             serial_q, serial_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    if (bus.clear) begin
      state_d  = IDLE;
      result_d = '0;
      cnt_d    = '0;
      serial_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          result_d = bus.load_data;
          cnt_d    = bus.amount;
          state_d  = (bus.amount != '0) ? SHIFT : DONE;
        end
        SHIFT: if (!bus.hold) begin
          result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
          serial_d = result_q[WIDTH-1];
          cnt_d    = cnt_q - 1'b1;
          state_d  = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.result     = result_q;
  assign bus.serial_out = serial_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_rotl_seq.sv
// tb_rotl_seq: directed vector table plus hand sequences for hold, clear and async reset
module tb_rotl_seq;
  import rotl_seq_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  rotl_seq_if bus ();
  rotl_seq dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] a;
    logic [WIDTH-1:0] r;
    logic             s;
  } vec_t;
  vec_t vecs[7];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a,
                        output int n, output int b);
    bus.load_data = d;
    bus.amount    = a;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    b = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) b++;
      tick();
      n++;
    end
    if (bus.busy) b++;
  endtask
  initial begin
    int n, b;
    vecs[0] = '{32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0};
    vecs[1] = '{32'h8000_0001, 5'd1,  32'h0000_0003, 1'b1};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{32'hF000_0000, 5'd31, 32'h7800_0000, 1'b0};
    vecs[4] = '{32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0};
    vecs[5] = '{32'hA5A5_A5A5, 5'd16, 32'hA5A5_A5A5, 1'b1};
    vecs[6] = '{32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.hold  = 1'b0;
    bus.load_data = '0;
    bus.amount    = '0;
    #12;
    chk("reset_result", bus.result, 32'h0);
    chk("reset_flags", {bus.serial_out, bus.busy, bus.done}, 32'h0);
    reset = 1'b0;
    tick();
    bus.load_data = 32'h1;
    bus.amount    = 5'd4;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("basic_load", {bus.busy, bus.done, bus.result}, {2'b10, 32'h1});
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("basic_step%0d", i), bus.result, 32'h1 << i);
    end
    chk("basic_done", bus.done, 32'h1);
    tick();
    chk("basic_idle", {bus.busy, bus.done}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].d, vecs[i].a, n, b);
      chk($sformatf("v%0d_latency", i), n, 32'(vecs[i].a));
      chk($sformatf("v%0d_busy", i), b, 32'(vecs[i].a) + 1);
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].r);
      chk($sformatf("v%0d_serial", i), bus.serial_out, vecs[i].s);
      tick();
      chk($sformatf("v%0d_after", i), {bus.busy, bus.done}, 32'h0);
    end
    bus.load_data = 32'h1;
    bus.amount    = 5'd3;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("hold_first", bus.result, 32'h2);
    bus.hold = 1'b1;
    bus.start = 1'b1;
    bus.load_data = 32'hFFFF_FFFF;
    bus.amount = 5'd1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("hold_frozen", {bus.serial_out, bus.busy, bus.done, bus.result}, {3'b010, 32'h2});
    bus.hold = 1'b0;
    tick();
    chk("hold_resume", bus.result, 32'h4);
    tick();
    chk("hold_final", {bus.done, bus.result}, {1'b1, 32'h8});
    tick();
    chk("hold_idle", {bus.busy, bus.done, bus.result}, {2'b00, 32'h8});
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.load_data = 32'h1234_5678;
    bus.amount = 5'd0;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("clr_start", {bus.busy, bus.done, bus.result}, 32'h0);
    tick();
    chk("clr_start_nodone", {bus.busy, bus.done, bus.result}, 32'h0);
    bus.load_data = 32'hFFFF_0000;
    bus.amount = 5'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("clr_mid_pre", {bus.busy, bus.result}, {1'b1, 32'hFFFC_0003});
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_mid", {bus.serial_out, bus.busy, bus.done, bus.result}, 32'h0);
    bus.load_data = 32'hFFFF_FFFF;
    bus.amount = 5'd20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("rst_mid_pre", {bus.serial_out, bus.busy, bus.result}, {2'b11, 32'hFFFF_FFFF});
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", {bus.serial_out, bus.busy, bus.done, bus.result}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_stays_idle", {bus.busy, bus.result}, 32'h0);
    run_op(32'h1, 5'd2, n, b);
    chk("rst_after_latency", n, 32'd2);
    chk("rst_after_result", bus.result, 32'h4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
